// File: rtl/fib_readback_checker.sv
// fib_readback_checker
//   Sweeps the register file in index order once the Fibonacci sequencer has
//   filled it, compares every register against a Fibonacci sequence rebuilt
//   here from the two seeds, and offers each value to the display path over a
//   valid/ready handshake. At the end of the sweep it reports pass/fail, the
//   number of mismatching registers and the index of the first mismatch.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high; forces IDLE and zeroes all outputs
//   start      begin a sweep (honoured only in IDLE or DONE)
//   regRead    register file read select
//   regData    register file read data (combinational from regRead)
//   dispValue  value read from register dispIndex
//   dispIndex  register index being presented
//   dispValid  dispValue/dispIndex valid
//   dispReady  display sink accepts the current value
//   busy       sweep in progress
//   done       sweep complete, held until the next start or reset
//   pass       while done: high iff no mismatch was seen
//   errCount   number of mismatching registers (0..16)
//   failIdx    index of the first mismatch, 0 if none
module fib_readback_checker #(
  parameter int                 DATA_W   = 16,
  parameter int                 NUM_REGS = 16,
  parameter logic [DATA_W-1:0]  SEED0    = DATA_W'(7),
  parameter logic [DATA_W-1:0]  SEED1    = DATA_W'(13)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [3:0]        regRead,
  input  logic [DATA_W-1:0] regData,
  output logic [DATA_W-1:0] dispValue,
  output logic [3:0]        dispIndex,
  output logic              dispValid,
  input  logic              dispReady,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [4:0]        errCount,
  output logic [3:0]        failIdx
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_PRESENT,
    S_DONE
  } state_t;

  state_t            state;
  logic [3:0]        idx;
  logic [DATA_W-1:0] expPrev;
  logic [DATA_W-1:0] expCur;

  // Modular Fibonacci step: the carry out of DATA_W bits is dropped.
  function automatic logic [DATA_W-1:0] fib_add(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    return a + b;
  endfunction

  wire launch    = ((state == S_IDLE) || (state == S_DONE)) && start;
  wire handshake = (state == S_PRESENT) && dispReady;

  // Control FSM; every output is a register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      regRead   <= '0;
      dispValue <= '0;
      dispIndex <= '0;
      dispValid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      errCount  <= '0;
      failIdx   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (launch) begin
            errCount <= '0;
            failIdx  <= '0;
            pass     <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b1;
            idx      <= '0;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          regRead <= idx;
          state   <= S_CAPTURE;
        end
        S_CAPTURE: begin
          dispValue <= regData;
          dispIndex <= idx;
          dispValid <= 1'b1;
          if (regData != expCur) begin
            errCount <= errCount + 5'd1;
            // errCount still 0 here means this is the first mismatch.
            if (errCount == '0) begin
              failIdx <= idx;
            end
          end
          state <= S_PRESENT;
        end
        S_PRESENT: begin
          if (handshake) begin
            dispValid <= 1'b0;
            if (idx == LAST_IDX) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (errCount == '0);
              state <= S_DONE;
            end else begin
              idx   <= idx + 4'd1;
              state <= S_ISSUE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Expected-value generator, driven only by the seeds. Reloaded on every
  // launch, so it needs no reset of its own.
  always_ff @(posedge clk) begin
    if (launch) begin
      expPrev <= '0;
      expCur  <= SEED0;
    end else if (handshake) begin
      expPrev <= expCur;
      expCur  <= (idx == 4'd0) ? SEED1 : fib_add(expPrev, expCur);
    end
  end

endmodule

// File: tb/tb_fib_readback_checker.sv
module tb_fib_readback_checker;

  localparam int N = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A: default seeds ----------------
  logic        reset, start, dispReady;
  logic [3:0]  regRead, dispIndex, failIdx;
  logic [15:0] regData, dispValue;
  logic        dispValid, busy, done, pass;
  logic [4:0]  errCount;
  logic [15:0] rf [N];

  assign regData = rf[regRead];

  fib_readback_checker #(.DATA_W(16), .NUM_REGS(16), .SEED0(16'd7), .SEED1(16'd13)) dut (
    .clk(clk), .reset(reset), .start(start), .regRead(regRead), .regData(regData),
    .dispValue(dispValue), .dispIndex(dispIndex), .dispValid(dispValid),
    .dispReady(dispReady), .busy(busy), .done(done), .pass(pass),
    .errCount(errCount), .failIdx(failIdx)
  );

  // ---------------- DUT B: seeds that overflow 16 bits ----------------
  logic        start_b, ready_b;
  logic [3:0]  regRead_b, dispIndex_b, failIdx_b;
  logic [15:0] regData_b, dispValue_b;
  logic        dispValid_b, busy_b, done_b, pass_b;
  logic [4:0]  errCount_b;
  logic [15:0] rf_b [N];

  assign regData_b = rf_b[regRead_b];

  fib_readback_checker #(.DATA_W(16), .NUM_REGS(16), .SEED0(16'd40000), .SEED1(16'd30000)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .regRead(regRead_b), .regData(regData_b),
    .dispValue(dispValue_b), .dispIndex(dispIndex_b), .dispValid(dispValid_b),
    .dispReady(ready_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .errCount(errCount_b), .failIdx(failIdx_b)
  );

  logic [15:0] gold [N];

  typedef struct {
    logic [3:0]  idx;
    logic [15:0] val;
  } disp_t;
  disp_t sb[$];

  typedef struct {
    string       name;
    int          fault_idx;   // -1 none, -2 every register zero
    logic [15:0] fault_val;
    int          hold_idx;
    int          hold_cyc;
    int          busy_start;
    int          exp_cycles;
    int          exp_err;
    int          exp_fidx;
    int          exp_pass;
  } vec_t;
  vec_t vecs[6];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_regRead"},   32'(regRead),   0);
    check({tag, "_dispValue"}, 32'(dispValue), 0);
    check({tag, "_dispIndex"}, 32'(dispIndex), 0);
    check({tag, "_dispValid"}, 32'(dispValid), 0);
    check({tag, "_busy"},      32'(busy),      0);
    check({tag, "_done"},      32'(done),      0);
    check({tag, "_pass"},      32'(pass),      0);
    check({tag, "_errCount"},  32'(errCount),  0);
    check({tag, "_failIdx"},   32'(failIdx),   0);
  endtask

  // One sweep on DUT A. cycles = edges from the start edge until done is seen,
  // -1 on timeout, -2 when the sweep was cut short by reset.
  task automatic run_sweep(input int hold_idx, input int hold_cyc, input int busy_start,
                           input int reset_idx, output int cycles);
    int    held = 0;
    bit    prev_hs = 0;
    disp_t e;
    sb.delete();
    @(negedge clk);
    start     = 1'b1;
    dispReady = 1'b1;
    for (int i = 0; i < N; i++) begin
      e.idx = 4'(i);
      e.val = rf[i];
      sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    cycles = -1;
    for (int n = 0; n < 300; n++) begin
      if (n > 0) @(negedge clk);
      if (n == 0) begin
        check("launch_busy",     32'(busy),     1);
        check("launch_done",     32'(done),     0);
        check("launch_errCount", 32'(errCount), 0);
        check("launch_failIdx",  32'(failIdx),  0);
      end
      if (done) begin
        cycles = n;
        break;
      end
      start = (busy_start != 0 && n == 10);
      if (prev_hs) check("valid_gap", 32'(dispValid), 0);
      prev_hs = 0;
      if (dispValid && int'(dispIndex) == reset_idx) begin
        reset = 1'b1;
        #1;
        check_zero("async_reset");
        start  = 1'b0;
        cycles = -2;
        return;
      end
      if (dispValid && int'(dispIndex) == hold_idx && held < hold_cyc) begin
        dispReady = 1'b0;
        held++;
        check("hold_dispIndex", 32'(dispIndex), 32'(hold_idx));
        check("hold_dispValue", 32'(dispValue), 32'(gold[hold_idx]));
        check("hold_regRead",   32'(regRead),   32'(hold_idx));
      end else begin
        dispReady = 1'b1;
      end
      if (dispValid && dispReady) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'(sb.size()), 1);
        end else begin
          e = sb.pop_front();
          check("disp_index", 32'(dispIndex), 32'(e.idx));
          check("disp_value", 32'(dispValue), 32'(e.val));
        end
        prev_hs = 1;
      end
    end
    start     = 1'b0;
    dispReady = 1'b1;
    if (cycles < 0) check("done_timeout", 32'(done), 1);
    check("sb_drained", 32'(sb.size()), 0);
  endtask

  initial begin
    int cyc;
    int nb;
    logic [31:0] big;

    gold = '{16'd7, 16'd13, 16'd20, 16'd33, 16'd53, 16'd86, 16'd139, 16'd225,
             16'd364, 16'd589, 16'd953, 16'd1542, 16'd2495, 16'd4037, 16'd6532, 16'd10569};

    //           name          fidx fval    hidx hcyc bs  cyc  err fidx pass
    vecs[0] = '{"clean",        -1, 16'd0,  -1,  0,  0,  48,  0,  0,  1};
    vecs[1] = '{"fault_r5",      5, 16'd87, -1,  0,  0,  48,  1,  5,  0};
    vecs[2] = '{"busy_start",   -1, 16'd0,  -1,  0,  1,  48,  0,  0,  1};
    vecs[3] = '{"backpressure", -1, 16'd0,   3, 10,  0,  58,  0,  0,  1};
    vecs[4] = '{"fault_r0",      0, 16'd8,  -1,  0,  0,  48,  1,  0,  0};
    vecs[5] = '{"all_zero",     -2, 16'd0,  -1,  0,  0,  48, 16,  0,  0};

    reset = 1'b1; start = 1'b0; dispReady = 1'b1; start_b = 1'b0; ready_b = 1'b1;
    for (int i = 0; i < N; i++) rf[i] = gold[i];
    rf_b[0] = 16'd40000;
    rf_b[1] = 16'd30000;
    for (int i = 2; i < N; i++) rf_b[i] = 16'((int'(rf_b[i-2]) + int'(rf_b[i-1])) % 65536);
    big = 32'd70000;
    rf_b[2] = big[15:0];

    #1;
    check_zero("por");
    #20;
    @(negedge clk);
    reset = 1'b0;

    // Table-driven sweeps; vector 2 starts from DONE after a failing sweep.
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < N; i++) rf[i] = (vecs[v].fault_idx == -2) ? 16'd0 : gold[i];
      if (vecs[v].fault_idx >= 0) rf[vecs[v].fault_idx] = vecs[v].fault_val;
      run_sweep(vecs[v].hold_idx, vecs[v].hold_cyc, vecs[v].busy_start, -1, cyc);
      check({vecs[v].name, "_cycles"},   32'(cyc),      32'(vecs[v].exp_cycles));
      check({vecs[v].name, "_pass"},     32'(pass),     32'(vecs[v].exp_pass));
      check({vecs[v].name, "_errCount"}, 32'(errCount), 32'(vecs[v].exp_err));
      check({vecs[v].name, "_failIdx"},  32'(failIdx),  32'(vecs[v].exp_fidx));
    end

    // Two faults: only the first sets failIdx.
    for (int i = 0; i < N; i++) rf[i] = gold[i];
    rf[4] = 16'd0;
    rf[9] = 16'd1;
    run_sweep(-1, 0, 0, -1, cyc);
    check("two_fault_errCount", 32'(errCount), 2);
    check("two_fault_failIdx",  32'(failIdx),  4);
    check("two_fault_pass",     32'(pass),     0);
    repeat (5) @(negedge clk);
    check("done_held", 32'(done), 1);

    // Reset mid-sweep at index 8, then a clean sweep.
    for (int i = 0; i < N; i++) rf[i] = gold[i];
    run_sweep(-1, 0, 0, 8, cyc);
    check("reset_reached", 32'(cyc), 32'(-2));
    @(negedge clk);
    check_zero("reset_held");
    reset = 1'b0;
    run_sweep(-1, 0, 0, -1, cyc);
    check("post_reset_cycles", 32'(cyc), 48);
    check("post_reset_pass",   32'(pass), 1);

    // Wrap-around seeds on the second instance.
    @(negedge clk);
    start_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_b = 1'b0;
    nb = -1;
    for (int n = 0; n < 300; n++) begin
      if (done_b) begin
        nb = n;
        break;
      end
      @(negedge clk);
    end
    check("wrap_cycles",   32'(nb),         48);
    check("wrap_pass",     32'(pass_b),     1);
    check("wrap_errCount", 32'(errCount_b), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
